// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, FSM encoding and default widths for the mul/div writeback unit
package cpu_pkg;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 4;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, WRITE = 2'd2} state_t;
endpackage

// File: rtl/muldiv_wb_unit_if.sv
// muldiv_wb_unit_if: operand launch from ID and dual register-file write ports
interface muldiv_wb_unit_if import cpu_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start, op;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [ADDR_W-1:0] dest;
    logic              busy, RegWrite, R0W, div_by_zero;
    logic [ADDR_W-1:0] WA1;
    logic [WIDTH-1:0]  WD1, R0D;
    modport master (output start, op, op_a, op_b, dest,
                    input  busy, RegWrite, WA1, WD1, R0W, R0D, div_by_zero);
    modport slave  (input  start, op, op_a, op_b, dest,
                    output busy, RegWrite, WA1, WD1, R0W, R0D, div_by_zero);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration
module muldiv_step import cpu_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);
    logic [WIDTH:0] sum, rem_s;
    logic           ge;
    // the remainder stays below op_b, so it always fits back into WIDTH bits
    always_comb begin
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, op_a} : '0);
        rem_s = {hi, lo[WIDTH-1]};
        ge    = rem_s >= {1'b0, op_b};
        hi_n  = op == OP_DIV ? WIDTH'(ge ? rem_s - {1'b0, op_b} : rem_s) : sum[WIDTH:1];
        lo_n  = op == OP_DIV ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_wb_unit.sv
// muldiv_wb_unit: iterative unsigned MUL/DIV feeding the primary and R0 register-file write ports
module muldiv_wb_unit import cpu_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic clk,
    input logic rst,
    muldiv_wb_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              op_q, dbz_q, accept, dbz_in, last;
    logic [WIDTH-1:0]  a_q, b_q, hi_q, lo_q, hi_n, lo_n, wd1_q, r0d_q;
    logic [ADDR_W-1:0] d_q, wa1_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op(op_q), .hi(hi_q), .lo(lo_q), .op_a(a_q), .op_b(b_q), .hi_n(hi_n), .lo_n(lo_n)
    );

    always_comb begin
        accept  = state == IDLE && bus.start;
        dbz_in  = bus.op == OP_DIV && bus.op_b == '0;
        last    = cnt == CNT_W'(WIDTH - 1);
        state_n = state == IDLE ? (accept ? (dbz_in ? WRITE : CALC) : IDLE)
                : state == CALC ? (last ? WRITE : CALC) : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // {hi,lo} ends up as {product high, product low} or {remainder, quotient}
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {op_q, dbz_q, cnt, a_q, b_q, hi_q, lo_q, d_q} <= '0;
            {wa1_q, wd1_q, r0d_q} <= '0;
        end else if (accept) begin
            op_q  <= bus.op;
            dbz_q <= dbz_in;
            cnt   <= '0;
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            d_q   <= bus.dest;
            hi_q  <= '0;
            lo_q  <= bus.op == OP_MUL ? bus.op_b : bus.op_a;
            if (dbz_in) begin
                wa1_q <= bus.dest;
                wd1_q <= '1;
                r0d_q <= bus.op_a;
            end
        end else if (state == CALC) begin
            cnt  <= cnt + 1'b1;
            hi_q <= hi_n;
            lo_q <= lo_n;
            if (last) begin
                wa1_q <= d_q;
                wd1_q <= lo_n;
                r0d_q <= hi_n;
            end
        end
    end

    // R0 is written through R0W only, so Rd==0 must not also raise RegWrite
    assign bus.busy        = state != IDLE;
    assign bus.R0W         = state == WRITE;
    assign bus.RegWrite    = state == WRITE && wa1_q != '0;
    assign bus.div_by_zero = state == WRITE && dbz_q;
    assign bus.WA1         = wa1_q;
    assign bus.WD1         = wd1_q;
    assign bus.R0D         = r0d_q;
endmodule

// File: tb/tb_muldiv_wb_unit.sv
// tb_muldiv_wb_unit: directed vectors against a cycle-level arithmetic model of the mul/div unit
module tb_muldiv_wb_unit;
    import cpu_pkg::*;
    localparam int W = 16;

    logic clk, rst;
    int   n_chk, n_pass;

    muldiv_wb_unit_if #(.WIDTH(W), .ADDR_W(4)) bif ();
    muldiv_wb_unit #(.WIDTH(W), .ADDR_W(4)) dut (.clk(clk), .rst(rst), .bus(bif));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // full result {secondary, primary} straight from unsigned arithmetic
    function automatic logic [31:0] ref_res(input logic o, input logic [15:0] a, input logic [15:0] b);
        if (o == OP_DIV && b == 0) return {a, 16'hFFFF};
        if (o == OP_DIV) return {a % b, a / b};
        return 32'(a) * 32'(b);
    endfunction

    logic        m_active, m_dbz;
    int          m_left;
    logic [3:0]  m_d, e_wa;
    logic [31:0] m_res;
    logic [15:0] e_wd, e_r0;

    // model: results appear WIDTH edges after acceptance (0 for divide-by-zero), for one cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 0; m_dbz <= 0; m_left <= 0; m_d <= 0; m_res <= 0;
            e_wa <= 0; e_wd <= 0; e_r0 <= 0;
        end else if (m_active) begin
            if (m_left == 0) m_active <= 0;
            else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    e_wa <= m_d;
                    e_wd <= m_res[15:0];
                    e_r0 <= m_res[31:16];
                end
            end
        end else if (bif.start) begin
            m_active <= 1;
            m_d      <= bif.dest;
            m_dbz    <= bif.op == OP_DIV && bif.op_b == 0;
            m_res    <= ref_res(bif.op, bif.op_a, bif.op_b);
            m_left   <= (bif.op == OP_DIV && bif.op_b == 0) ? 0 : W;
            if (bif.op == OP_DIV && bif.op_b == 0) begin
                e_wa <= bif.dest;
                e_wd <= 16'hFFFF;
                e_r0 <= bif.op_a;
            end
        end
    end

    always @(negedge clk) begin
        logic strobe;
        strobe = m_active && m_left == 0;
        chk("busy", 32'(bif.busy), 32'(m_active));
        chk("R0W", 32'(bif.R0W), 32'(strobe));
        chk("RegWrite", 32'(bif.RegWrite), 32'(strobe && e_wa != 0));
        chk("div_by_zero", 32'(bif.div_by_zero), 32'(strobe && m_dbz));
        chk("WA1", 32'(bif.WA1), 32'(e_wa));
        chk("WD1", 32'(bif.WD1), 32'(e_wd));
        chk("R0D", 32'(bif.R0D), 32'(e_r0));
    end

    task automatic launch(input logic o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
        @(negedge clk);
        bif.start = 1; bif.op = o; bif.op_a = a; bif.op_b = b; bif.dest = d;
        @(negedge clk);
        bif.start = 0;
    endtask

    task automatic run(input logic o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d,
                       input logic [15:0] xwd, input logic [15:0] xr0, input logic xdbz,
                       input int xlat, input logic poke);
        int n;
        launch(o, a, b, d);
        n = 0;
        while (!bif.R0W && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("lit_latency", 32'(n), 32'(xlat));
        chk("lit_WA1", 32'(bif.WA1), 32'(d));
        chk("lit_WD1", 32'(bif.WD1), 32'(xwd));
        chk("lit_R0D", 32'(bif.R0D), 32'(xr0));
        chk("lit_dbz", 32'(bif.div_by_zero), 32'(xdbz));
        chk("lit_RegWrite", 32'(bif.RegWrite), 32'(d != 0));
        if (poke) begin
            bif.start = 1; bif.op = OP_MUL; bif.op_a = 16'h1111; bif.op_b = 16'h0002; bif.dest = 4'd9;
        end
        @(negedge clk);
        bif.start = 0;
        chk("lit_busy_after", 32'(bif.busy), 0);
        chk("lit_strobe_after", 32'(bif.R0W), 0);
    endtask

    initial begin
        int n;
        n_chk = 0; n_pass = 0;
        rst = 0;
        bif.start = 0; bif.op = 0; bif.op_a = 0; bif.op_b = 0; bif.dest = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bif.busy), 0);
        chk("rst_WD1", 32'(bif.WD1), 0);
        #2 rst = 1;
        run(OP_MUL, 16'h0F00, 16'h0050, 4'd3, 16'hB000, 16'h0004, 0, W, 0);
        run(OP_MUL, 16'hFFFF, 16'hFFFF, 4'd7, 16'h0001, 16'hFFFE, 0, W, 0);
        run(OP_DIV, 16'h00FF, 16'h0002, 4'd5, 16'h007F, 16'h0001, 0, W, 0);
        run(OP_DIV, 16'hAAAA, 16'h0000, 4'd8, 16'hFFFF, 16'hAAAA, 1, 0, 1);
        run(OP_MUL, 16'h0040, 16'h0024, 4'd0, 16'h0900, 16'h0000, 0, W, 0);
        run(OP_DIV, 16'hFFFF, 16'hFFFF, 4'd1, 16'h0001, 16'h0000, 0, W, 0);
        run(OP_DIV, 16'h0005, 16'h0009, 4'd2, 16'h0000, 16'h0005, 0, W, 0);
        launch(OP_DIV, 16'h1234, 16'h0007, 4'd2);
        repeat (4) @(negedge clk);
        #2 rst = 0;
        #1;
        chk("midrst_busy", 32'(bif.busy), 0);
        chk("midrst_WD1", 32'(bif.WD1), 0);
        chk("midrst_R0D", 32'(bif.R0D), 0);
        chk("midrst_WA1", 32'(bif.WA1), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (bif.R0W || bif.RegWrite) n++;
        end
        chk("no_strobe_after_rst", 32'(n), 0);
        run(OP_MUL, 16'h0002, 16'h0003, 4'd4, 16'h0006, 16'h0000, 0, W, 0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
